render_chain_source: RTL and testbench

//  Head of the rect_renderer chain. Generates the raster scan stream (program=0, x, y, background colour)

---
 rtl/render_pkg.sv | 22 ++
 rtl/render_chain_source_cmd_fifo.sv | 48 ++++
 rtl/render_chain_source.sv | 109 ++++++++++
 tb/tb_render_chain_source.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared widths, command record and register IDs for the rect_renderer chain.
package render_pkg;

    localparam int X_W    = 11;
    localparam int Y_W    = 12;
    localparam int DATA_W = 12;
    localparam int CMD_W  = X_W + Y_W + DATA_W;

    // Register IDs carried in y on program beats; rect_renderer decodes the same values.
    localparam logic [Y_W-1:0] REG_X     = 12'd0;
    localparam logic [Y_W-1:0] REG_Y     = 12'd1;
    localparam logic [Y_W-1:0] REG_W     = 12'd2;
    localparam logic [Y_W-1:0] REG_H     = 12'd3;
    localparam logic [Y_W-1:0] REG_COLOR = 12'd4;

    typedef struct packed {
        logic [X_W-1:0]    stage;
        logic [Y_W-1:0]    reg_id;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/render_chain_source_cmd_fifo.sv
// Synchronous FIFO for host commands; head is visible combinationally from storage.
// Latency: a push is visible at head the cycle after; full/empty are derived from registered pointers.
// Backpressure: push ignored when full, pop ignored when empty.
module cmd_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/render_chain_source.sv
// Raster scan source for the renderer chain; splices queued programming commands into vertical blanking.
// Latency: one registered cycle from scan counters to outputs; scan never stalls.
// Backpressure: cmd_ready drops while the command queue is full (and during reset).
module render_chain_source
    import render_pkg::*;
#(
    parameter int                H_ACTIVE   = 640,
    parameter int                H_TOTAL    = 800,
    parameter int                V_ACTIVE   = 480,
    parameter int                V_TOTAL    = 525,
    parameter logic [DATA_W-1:0] BG_COLOR   = 12'h000,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_stage,
    input  logic [Y_W-1:0]    cmd_reg,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              program_out,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_start
);

    // Injection at v=0 would break the frame_start guarantee, so V_ACTIVE must be at least 1.
    if (H_ACTIVE > H_TOTAL || H_TOTAL > 2048 || V_ACTIVE < 1 || V_ACTIVE >= V_TOTAL ||
        V_TOTAL > 4096 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("render_chain_source: illegal parameter set");
    end

    logic [X_W-1:0] hcnt;
    logic [Y_W-1:0] vcnt;
    logic           h_last;
    logic           v_last;
    logic           in_vblank;
    logic           inject;
    logic           ready_en;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    cmd_t           cmd_in;
    cmd_t           cmd_head;

    assign h_last    = (hcnt == X_W'(H_TOTAL - 1));
    assign v_last    = (vcnt == Y_W'(V_TOTAL - 1));
    assign in_vblank = (vcnt >= Y_W'(V_ACTIVE));
    assign inject    = in_vblank && !fifo_empty;

    // ready_en keeps cmd_ready low while in reset and for the reset cycle itself.
    assign cmd_ready = ready_en && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign cmd_in    = '{stage: cmd_stage, reg_id: cmd_reg, data: cmd_data};

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (cmd_in),
        .pop      (inject),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (cmd_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            program_out <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            data_out    <= BG_COLOR;
            frame_start <= 1'b0;
        end else if (inject) begin
            program_out <= 1'b1;
            x_out       <= cmd_head.stage;
            y_out       <= cmd_head.reg_id;
            data_out    <= cmd_head.data;
            frame_start <= 1'b0;
        end else begin
            program_out <= 1'b0;
            x_out       <= hcnt;
            y_out       <= vcnt;
            data_out    <= BG_COLOR;
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_render_chain_source.sv
// Bench for render_chain_source on a 16x8 raster: per-beat scoreboard plus directed scenario checks.
module tb_render_chain_source;
    import render_pkg::*;

    localparam int HA = 10, HT = 16, VA = 5, VT = 8, DEPTH = 8;
    localparam logic [11:0] BG = 12'h0A5;

    typedef struct packed {
        logic        prog;
        logic [10:0] x;
        logic [11:0] y;
        logic [11:0] d;
        logic        fs;
        logic        rdy;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_stage = '0;
    logic [11:0] cmd_reg = '0;
    logic [11:0] cmd_data = '0;
    logic        program_out;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [11:0] data_out;
    logic        frame_start;

    int total = 0;
    int bad = 0;

    render_chain_source #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .BG_COLOR(BG), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_stage(cmd_stage), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .program_out(program_out), .x_out(x_out), .y_out(y_out),
        .data_out(data_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: on every edge, push the beat the DUT must show after that edge.
    beat_t       exp_q[$];
    logic [34:0] m_fifo[$];
    int          m_h = 0, m_v = 0;
    logic        m_rdy = 1'b0;
    beat_t       m_e;
    logic [34:0] m_c;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_h = 0; m_v = 0; m_fifo.delete(); m_rdy = 1'b0;
            m_e = '{prog: 1'b0, x: 11'd0, y: 12'd0, d: BG, fs: 1'b0, rdy: 1'b0};
        end else begin
            if (m_v >= VA && m_fifo.size() > 0) begin
                m_c = m_fifo.pop_front();
                m_e = '{prog: 1'b1, x: m_c[34:24], y: m_c[23:12], d: m_c[11:0], fs: 1'b0, rdy: 1'b0};
            end else begin
                m_e = '{prog: 1'b0, x: 11'(m_h), y: 12'(m_v), d: BG,
                        fs: (m_h == 0 && m_v == 0), rdy: 1'b0};
            end
            if (cmd_valid && m_rdy) m_fifo.push_back({cmd_stage, cmd_reg, cmd_data});
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            m_rdy = (m_fifo.size() < DEPTH);
            m_e.rdy = m_rdy;
        end
        exp_q.push_back(m_e);
    end

    beat_t mon_e, mon_a;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{prog: program_out, x: x_out, y: y_out, d: data_out, fs: frame_start, rdy: cmd_ready};
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL beat: got prog=%0d x=%0d y=%0d d=%0h fs=%0d rdy=%0d want prog=%0d x=%0d y=%0d d=%0h fs=%0d rdy=%0d",
                         mon_a.prog, mon_a.x, mon_a.y, mon_a.d, mon_a.fs, mon_a.rdy,
                         mon_e.prog, mon_e.x, mon_e.y, mon_e.d, mon_e.fs, mon_e.rdy);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic chk_scan(input string name, input int x, input int y, input logic fs);
        chk(name, {program_out, 4'(0), x_out, y_out, data_out, frame_start},
            {1'b0, 4'(0), 11'(x), 12'(y), BG, fs});
    endtask

    task automatic chk_prog(input string name, input int st, input int rg, input logic [11:0] d);
        chk(name, {program_out, x_out, y_out, data_out, frame_start},
            {1'b1, 11'(st), 12'(rg), d, 1'b0});
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < 400);
        chk("wait frame_start", frame_start, 1);
    endtask

    task automatic wait_prog();
        int n = 0;
        do begin @(negedge clk); n++; end while (!program_out && n < 400);
        chk("wait program beat", program_out, 1);
    endtask

    task automatic wait_scan(input int x, input int y);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(!program_out && x_out == 11'(x) && y_out == 12'(y)) && n < 400);
        chk("wait scan pos", {x_out, y_out}, {11'(x), 12'(y)});
    endtask

    // Called at a negedge; returns at the negedge after acceptance with cmd_valid low.
    task automatic push_cmd(input int st, input int rg, input logic [11:0] d);
        int n = 0;
        cmd_stage = 11'(st); cmd_reg = 12'(rg); cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
        chk("push accepted", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n, progs;
        // 1: reset held three cycles, then release
        repeat (3) @(negedge clk);
        chk("reset outputs", {program_out, x_out, y_out, data_out, frame_start, cmd_ready},
            {1'b0, 11'd0, 12'd0, BG, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);
        chk_scan("first beat", 0, 0, 1);
        chk("ready after release", cmd_ready, 1);
        @(negedge clk);
        chk_scan("second beat", 1, 0, 0);
        @(negedge clk);
        chk_scan("third beat", 2, 0, 0);

        // 2: free-run frame period and line/frame wrap
        wait_fs();
        n = 0; progs = 0;
        do begin @(negedge clk); n++; if (program_out) progs++; end while (!frame_start && n < 400);
        chk("frame period", n, 128);
        chk("no program beats", progs, 0);
        wait_scan(15, 0);
        @(negedge clk);
        chk_scan("line wrap", 0, 1, 0);

        // 3: single command lands on the first vblank slot
        wait_scan(3, 1);
        push_cmd(2, 4, 12'hF00);
        wait_scan(15, 4);
        @(negedge clk);
        chk_prog("inject at (0,5)", 2, 4, 12'hF00);
        @(negedge clk);
        chk_scan("after inject", 1, 5, 0);

        // 4: fill queue, hold a 9th until the first pop frees a slot
        wait_fs();
        for (int i = 1; i <= 8; i++) push_cmd(i, i % 5, 12'(12'h100 + i));
        chk("ready low when full", cmd_ready, 0);
        cmd_stage = 11'd9; cmd_reg = 12'd4; cmd_data = 12'h109; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
        chk_prog("ready returns on first pop", 1, 1, 12'h101);
        chk("prev slot blanking start", {x_out, y_out}, {11'd1, 12'd1});
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 2; i <= 9; i++) begin
            chk_prog("burst order", i, i % 5, 12'(12'h100 + i));
            @(negedge clk);
        end
        chk_scan("scan after burst", 9, 5, 0);

        // 5: reset after one injection discards the rest
        wait_fs();
        for (int i = 1; i <= 3; i++) push_cmd(5, i, 12'(12'h500 + i));
        wait_prog();
        chk_prog("pre-reset inject", 5, 1, 12'h501);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid reset ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_scan("restart at origin", 0, 0, 1);
        progs = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (program_out) progs++; end
        chk("discarded commands", progs, 0);

        // 6: simultaneous push and pop at count 4
        wait_fs();
        for (int i = 1; i <= 5; i++) push_cmd(6, i - 1, 12'(12'h600 + i));
        wait_prog();
        chk_prog("sim first", 6, 0, 12'h601);
        chk("ready at count 4", cmd_ready, 1);
        cmd_stage = 11'd6; cmd_reg = 12'd2; cmd_data = 12'h606; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready after push+pop", cmd_ready, 1);
        for (int i = 2; i <= 6; i++) begin
            chk_prog("sim order", 6, (i == 6) ? 2 : i - 1, 12'(12'h600 + i));
            @(negedge clk);
        end
        chk_scan("sim drained", 6, 5, 0);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
